// File: rtl/osnt_bram_pkg.sv
// Shared types and constants for the OSNT lane-write block RAM.
package osnt_bram_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } bram_state_e;

   localparam int WM_READ_FIRST  = 32'sd0;
   localparam int WM_WRITE_FIRST = 32'sd1;

   function automatic int lane_count(input int data_width, input int lane_width);
      return data_width / lane_width;
   endfunction

endpackage

// File: rtl/osnt_bram_lane_if.sv
// Access/clear bus between the replay/AXI side (master) and the lane RAM (slave).
interface osnt_bram_lane_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 736,
   parameter int LANE_WIDTH = 32
);
   localparam int NUM_LANES = osnt_bram_pkg::lane_count(DATA_WIDTH, LANE_WIDTH);

   logic                  bram_en;
   logic [NUM_LANES-1:0]  bram_we;
   logic [ADDR_WIDTH-1:0] bram_addr;
   logic [DATA_WIDTH-1:0] bram_wrdata;
   logic [DATA_WIDTH-1:0] bram_rddata;
   logic                  bram_rdvalid;
   logic                  bram_clr_req;
   logic                  bram_busy;

   modport master (
      output bram_en, bram_we, bram_addr, bram_wrdata, bram_clr_req,
      input  bram_rddata, bram_rdvalid, bram_busy
   );

   modport slave (
      input  bram_en, bram_we, bram_addr, bram_wrdata, bram_clr_req,
      output bram_rddata, bram_rdvalid, bram_busy
   );

endinterface

// File: rtl/osnt_bram_clear_seq.sv
// Clear engine: walks every word address once, one per cycle, after reset or on request.
module osnt_bram_clear_seq
   import osnt_bram_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clr_req,
   output logic                  busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   bram_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

   // Next state; a request arriving mid-clear is ignored rather than restarting.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d    = ST_CLEAR;
               clr_addr_d = '0;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            if (clr_addr_q == LAST_ADDR) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CLEAR;
            end
         end
         default: begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
         end
      endcase
   end

   // State and address registers; reset always restarts the clear from word 0.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign busy     = (state_q == ST_CLEAR);
   assign clr_we   = (state_q == ST_CLEAR);
   assign clr_addr = clr_addr_q;

endmodule

// File: rtl/osnt_bram_lane.sv
// Single-port lane-write-enabled packet store with clear engine and 1/2-cycle read pipe.
module osnt_bram_lane
   import osnt_bram_pkg::*;
#(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 736,
   parameter int LANE_WIDTH   = 32,
   parameter int READ_LATENCY = 1,
   parameter int WRITE_MODE   = 0,
   parameter     RAM_STYLE    = "ultra"
) (
   input  logic            bram_clk,
   input  logic            bram_rstn,
   osnt_bram_lane_if.slave bus
);

   localparam int NUM_LANES = lane_count(DATA_WIDTH, LANE_WIDTH);
   localparam int DEPTH     = 2 ** ADDR_WIDTH;

   if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lane_width
      $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
   end
   if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
   end
   if ((WRITE_MODE != WM_READ_FIRST) && (WRITE_MODE != WM_WRITE_FIRST)) begin : g_bad_write_mode
      $error("WRITE_MODE must be 0 or 1");
   end

   (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  busy_s;
   logic                  clr_we_s;
   logic [ADDR_WIDTH-1:0] clr_addr_s;
   logic                  acc_s;
   logic                  wr_en_s;
   logic [ADDR_WIDTH-1:0] wr_addr_s;
   logic [DATA_WIDTH-1:0] wr_data_s;
   logic [NUM_LANES-1:0]  wr_lanes_s;
   logic [DATA_WIDTH-1:0] rd_word_s;
   logic [DATA_WIDTH-1:0] rd_merge_s;

   logic [DATA_WIDTH-1:0] rd_s1_q, rd_s1_d;
   logic [DATA_WIDTH-1:0] rd_s2_q, rd_s2_d;
   logic                  vld_s1_q, vld_s1_d;
   logic                  vld_s2_q, vld_s2_d;

   osnt_bram_clear_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_seq (
      .clk      (bram_clk),
      .rstn     (bram_rstn),
      .clr_req  (bus.bram_clr_req),
      .busy     (busy_s),
      .clr_we   (clr_we_s),
      .clr_addr (clr_addr_s)
   );

   assign acc_s = bram_rstn & bus.bram_en & ~busy_s;

   // Write-port mux: the clear engine owns the port whenever it runs.
   always_comb begin
      wr_en_s    = 1'b0;
      wr_addr_s  = bus.bram_addr;
      wr_data_s  = bus.bram_wrdata;
      wr_lanes_s = bus.bram_we;
      if (clr_we_s) begin
         wr_en_s    = bram_rstn;
         wr_addr_s  = clr_addr_s;
         wr_data_s  = '0;
         wr_lanes_s = '1;
      end else begin
         wr_en_s    = acc_s & (|bus.bram_we);
         wr_addr_s  = bus.bram_addr;
         wr_data_s  = bus.bram_wrdata;
         wr_lanes_s = bus.bram_we;
      end
   end

   // Lane-masked array write; contents are deliberately left alone by reset.
   always_ff @(posedge bram_clk) begin
      for (int k = 0; k < NUM_LANES; k++) begin
         if (wr_en_s && wr_lanes_s[k]) begin
            mem_q[wr_addr_s][k*LANE_WIDTH +: LANE_WIDTH] <= wr_data_s[k*LANE_WIDTH +: LANE_WIDTH];
         end
      end
   end

   // Read word as seen by the access; write-first substitutes the enabled lanes.
   always_comb begin
      rd_word_s  = mem_q[bus.bram_addr];
      rd_merge_s = rd_word_s;
      for (int k = 0; k < NUM_LANES; k++) begin
         if ((WRITE_MODE == WM_WRITE_FIRST) && bus.bram_we[k]) begin
            rd_merge_s[k*LANE_WIDTH +: LANE_WIDTH] = bus.bram_wrdata[k*LANE_WIDTH +: LANE_WIDTH];
         end else begin
            rd_merge_s[k*LANE_WIDTH +: LANE_WIDTH] = rd_word_s[k*LANE_WIDTH +: LANE_WIDTH];
         end
      end
   end

   // Read pipe; data stages only load with a valid so the output holds between accesses.
   always_comb begin
      vld_s1_d = acc_s;
      vld_s2_d = vld_s1_q;
      rd_s1_d  = rd_s1_q;
      rd_s2_d  = rd_s2_q;
      if (acc_s) begin
         rd_s1_d = rd_merge_s;
      end else begin
         rd_s1_d = rd_s1_q;
      end
      if (vld_s1_q) begin
         rd_s2_d = rd_s1_q;
      end else begin
         rd_s2_d = rd_s2_q;
      end
   end

   // Read pipe registers.
   always_ff @(posedge bram_clk) begin
      if (!bram_rstn) begin
         rd_s1_q  <= '0;
         rd_s2_q  <= '0;
         vld_s1_q <= 1'b0;
         vld_s2_q <= 1'b0;
      end else begin
         rd_s1_q  <= rd_s1_d;
         rd_s2_q  <= rd_s2_d;
         vld_s1_q <= vld_s1_d;
         vld_s2_q <= vld_s2_d;
      end
   end

   assign bus.bram_rddata  = (READ_LATENCY == 2) ? rd_s2_q  : rd_s1_q;
   assign bus.bram_rdvalid = (READ_LATENCY == 2) ? vld_s2_q : vld_s1_q;
   assign bus.bram_busy    = busy_s;

endmodule

// File: tb/tb_osnt_bram_lane.sv
// Directed bench: dut_a is latency 1 / read-first, dut_b is latency 2 / write-first, same stimulus.
module tb_osnt_bram_lane;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_total = 0;
   int   n_bad   = 0;

   osnt_bram_lane_if #(.ADDR_WIDTH(4), .DATA_WIDTH(96), .LANE_WIDTH(32)) if_a ();
   osnt_bram_lane_if #(.ADDR_WIDTH(4), .DATA_WIDTH(96), .LANE_WIDTH(32)) if_b ();

   assign if_b.bram_en      = if_a.bram_en;
   assign if_b.bram_we      = if_a.bram_we;
   assign if_b.bram_addr    = if_a.bram_addr;
   assign if_b.bram_wrdata  = if_a.bram_wrdata;
   assign if_b.bram_clr_req = if_a.bram_clr_req;

   osnt_bram_lane #(
      .ADDR_WIDTH(4), .DATA_WIDTH(96), .LANE_WIDTH(32),
      .READ_LATENCY(1), .WRITE_MODE(0), .RAM_STYLE("ultra")
   ) dut_a (
      .bram_clk  (clk),
      .bram_rstn (rstn),
      .bus       (if_a)
   );

   osnt_bram_lane #(
      .ADDR_WIDTH(4), .DATA_WIDTH(96), .LANE_WIDTH(32),
      .READ_LATENCY(2), .WRITE_MODE(1), .RAM_STYLE("ultra")
   ) dut_b (
      .bram_clk  (clk),
      .bram_rstn (rstn),
      .bus       (if_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic [3:0] addr, input logic [2:0] we, input logic [95:0] wd);
      if_a.bram_en     = 1'b1;
      if_a.bram_we     = we;
      if_a.bram_addr   = addr;
      if_a.bram_wrdata = wd;
      tick();
      if_a.bram_en     = 1'b0;
      if_a.bram_we     = 3'b000;
   endtask

   function automatic logic [95:0] pat(input int i);
      logic [31:0] w;
      w = 32'hA5A5_A500 + 32'(i);
      return {w, ~w, w ^ 32'h0F0F_0F0F};
   endfunction

   localparam logic [95:0] W1 = 96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
   localparam logic [95:0] W2 = 96'h0000_3333_1111_2222_0000_4444;
   localparam logic [95:0] W3 = 96'hAAAA_BBBB_1111_2222_EEEE_FFFF;
   localparam logic [95:0] DX = 96'h0123_4567_89AB_CDEF_0F1E_2D3C;
   localparam logic [95:0] DY = 96'hFEDC_BA98_7654_3210_A1B2_C3D4;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int first_t;
      int last_t;
      int n_v;
      logic vld_seen;

      if_a.bram_en      = 1'b0;
      if_a.bram_we      = 3'b000;
      if_a.bram_addr    = 4'd0;
      if_a.bram_wrdata  = 96'd0;
      if_a.bram_clr_req = 1'b0;

      // 1: reset, then a 16-cycle clear, then everything reads zero
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_rd_a", if_a.bram_rddata, 96'd0);
         chk("rst_rd_b", if_b.bram_rddata, 96'd0);
         chk("rst_vld", 96'({if_a.bram_rdvalid, if_b.bram_rdvalid}), 96'd0);
         chk("rst_busy", 96'({if_a.bram_busy, if_b.bram_busy}), 96'd3);
      end
      rstn = 1'b1;
      n = 0;
      while (if_a.bram_busy && n < 40) begin
         n++;
         tick();
      end
      chk("clr_len", 96'(n), 96'd16);
      chk("clr_len_b", 96'(if_b.bram_busy), 96'd0);
      for (int i = 0; i < 16; i++) begin
         access(4'(i), 3'b000, 96'd0);
         chk("clr_zero", if_a.bram_rddata, 96'd0);
         chk("clr_zero_vld", 96'(if_a.bram_rdvalid), 96'd1);
      end
      tick();

      // 2: lane-masked write and read latency
      access(4'd5, 3'b111, W1);
      tick();
      access(4'd5, 3'b010, W2);
      chk("t2_rf_old", if_a.bram_rddata, W1);
      tick();
      chk("t2_wf_merge", if_b.bram_rddata, W3);
      access(4'd5, 3'b000, 96'd0);
      chk("t2_a_vld", 96'(if_a.bram_rdvalid), 96'd1);
      chk("t2_a_data", if_a.bram_rddata, W3);
      chk("t2_b_vld_early", 96'(if_b.bram_rdvalid), 96'd0);
      tick();
      chk("t2_a_vld_pulse", 96'(if_a.bram_rdvalid), 96'd0);
      chk("t2_b_vld", 96'(if_b.bram_rdvalid), 96'd1);
      chk("t2_b_data", if_b.bram_rddata, W3);
      tick();
      chk("t2_b_vld_pulse", 96'(if_b.bram_rdvalid), 96'd0);

      // 3: read-during-write, read-first vs write-first
      access(4'd7, 3'b111, DX);
      tick();
      tick();
      access(4'd7, 3'b111, DY);
      chk("t3_read_first", if_a.bram_rddata, DX);
      tick();
      chk("t3_write_first", if_b.bram_rddata, DY);
      tick();
      chk("t3_hold", if_a.bram_rddata, DX);
      access(4'd7, 3'b000, 96'd0);
      chk("t3_stored", if_a.bram_rddata, DY);
      tick();

      // 4: back-to-back stream on the latency-2 instance
      for (int i = 0; i < 16; i++) begin
         access(4'(i), 3'b111, pat(i));
      end
      tick();
      tick();
      first_t = -1;
      last_t  = -1;
      n_v     = 0;
      for (int t = 1; t <= 20; t++) begin
         if_a.bram_en   = (t <= 16);
         if_a.bram_we   = 3'b000;
         if_a.bram_addr = 4'(t - 1);
         tick();
         if (if_b.bram_rdvalid) begin
            if (first_t < 0) first_t = t;
            last_t = t;
            chk("t4_data", if_b.bram_rddata, pat(n_v));
            n_v++;
         end
      end
      if_a.bram_en = 1'b0;
      chk("t4_count", 96'(n_v), 96'd16);
      chk("t4_first", 96'(first_t), 96'd2);
      chk("t4_last", 96'(last_t), 96'd17);

      // 5: clear request; access and second request while busy are ignored
      if_a.bram_clr_req = 1'b1;
      tick();
      if_a.bram_clr_req = 1'b0;
      n = 0;
      vld_seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (!if_a.bram_busy) break;
         n++;
         vld_seen = vld_seen | if_a.bram_rdvalid | if_b.bram_rdvalid;
         if_a.bram_en      = (k == 2);
         if_a.bram_we      = 3'b111;
         if_a.bram_addr    = 4'd3;
         if_a.bram_wrdata  = {96{1'b1}};
         if_a.bram_clr_req = (k == 6);
         tick();
      end
      vld_seen = vld_seen | if_a.bram_rdvalid | if_b.bram_rdvalid;
      if_a.bram_en      = 1'b0;
      if_a.bram_we      = 3'b000;
      if_a.bram_clr_req = 1'b0;
      chk("t5_busy_len", 96'(n), 96'd16);
      chk("t5_no_vld", 96'(vld_seen), 96'd0);
      access(4'd3, 3'b000, 96'd0);
      chk("t5_addr3", if_a.bram_rddata, 96'd0);
      access(4'd15, 3'b000, 96'd0);
      chk("t5_addr15", if_a.bram_rddata, 96'd0);
      tick();

      // 6: reset in the middle of a clear restarts it from word 0
      access(4'd1, 3'b111, pat(1));
      access(4'd1, 3'b000, 96'd0);
      tick();
      chk("t6_pre_a", if_a.bram_rddata, pat(1));
      chk("t6_pre_b", if_b.bram_rddata, pat(1));
      if_a.bram_clr_req = 1'b1;
      tick();
      if_a.bram_clr_req = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      rstn = 1'b0;
      tick();
      tick();
      chk("t6_rst_rd_a", if_a.bram_rddata, 96'd0);
      chk("t6_rst_rd_b", if_b.bram_rddata, 96'd0);
      chk("t6_rst_busy", 96'(if_a.bram_busy), 96'd1);
      rstn = 1'b1;
      n = 0;
      while (if_a.bram_busy && n < 40) begin
         n++;
         tick();
      end
      chk("t6_busy_len", 96'(n), 96'd16);
      access(4'd1, 3'b000, 96'd0);
      chk("t6_addr1", if_a.bram_rddata, 96'd0);
      tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
